// File: rtl/counter_step_arbiter.sv
// Round-robin front end for a shared 3-bit up/down step counter: accepts one
// command at a time, issues one cnt_en strobe per step and mirrors the count.
module counter_step_arbiter #(
  parameter logic [2:0] INIT_COUNT = 3'd0,
  parameter logic [3:0] STEP_GAP   = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_dir,
  input  logic [2:0] req0_steps,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_dir,
  input  logic [2:0] req1_steps,
  output logic       req1_ready,
  output logic       cnt_en,
  output logic       cnt_mode,
  output logic [2:0] count,
  output logic       busy,
  output logic       done,
  output logic       done_id
);

  typedef enum logic [1:0] {IDLE, STEP, GAP, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [2:0] remaining_q, remaining_d;
  logic [3:0] gap_q, gap_d;
  logic       dir_q, dir_d;
  logic       id_q, id_d;
  logic       last_grant_q, last_grant_d;

  logic       grant0, grant1;
  logic [2:0] sel_steps;

  // A lone requester always wins; on contention the one not served last wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;
  assign sel_steps  = grant1 ? req1_steps : req0_steps;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    remaining_d  = remaining_q;
    gap_d        = gap_q;
    dir_d        = dir_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          id_d         = grant1;
          dir_d        = grant1 ? req1_dir : req0_dir;
          last_grant_d = grant1;
          remaining_d  = sel_steps;
          state_d      = (sel_steps == 3'd0) ? DONE : STEP;
        end
      end
      STEP: begin
        count_d     = dir_q ? count_q + 3'd1 : count_q - 3'd1;
        remaining_d = remaining_q - 3'd1;
        if (remaining_q == 3'd1) begin
          state_d = DONE;
        end else if (STEP_GAP == 4'd0) begin
          state_d = STEP;
        end else begin
          gap_d   = STEP_GAP;
          state_d = GAP;
        end
      end
      GAP: begin
        // gap_q was loaded with STEP_GAP, so this state lasts STEP_GAP cycles.
        if (gap_q <= 4'd1) begin
          state_d = STEP;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= INIT_COUNT;
      remaining_q  <= 3'd0;
      gap_q        <= 4'd0;
      dir_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      remaining_q  <= remaining_d;
      gap_q        <= gap_d;
      dir_q        <= dir_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cnt_en   = (state_q == STEP);
  assign cnt_mode = dir_q;
  assign count    = count_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign done_id  = id_q;

endmodule

// File: tb/tb_counter_step_arbiter.sv
// Directed bench for counter_step_arbiter; a second instance with a step gap
// of 2 shares the stimulus and is only checked in the gap scenario.
module tb_counter_step_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req0_dir = 1'b0;
  logic [2:0] req0_steps = 3'd0;
  logic       req1_valid = 1'b0, req1_dir = 1'b0;
  logic [2:0] req1_steps = 3'd0;

  logic       req0_ready, req1_ready, cnt_en, cnt_mode, busy, done, done_id;
  logic [2:0] count;
  logic       g_req0_ready, g_req1_ready, g_cnt_en, g_cnt_mode, g_busy, g_done, g_done_id;
  logic [2:0] g_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_cnt;
  int exp_grant;
  int grants;
  int last_id;
  bit g0, g1;

  always #5 clk = ~clk;

  counter_step_arbiter #(.INIT_COUNT(3'd0), .STEP_GAP(4'd0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dir(req0_dir), .req0_steps(req0_steps), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir), .req1_steps(req1_steps), .req1_ready(req1_ready),
    .cnt_en(cnt_en), .cnt_mode(cnt_mode), .count(count), .busy(busy), .done(done), .done_id(done_id)
  );

  counter_step_arbiter #(.INIT_COUNT(3'd0), .STEP_GAP(4'd2)) dut_g (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dir(req0_dir), .req0_steps(req0_steps), .req0_ready(g_req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir), .req1_steps(req1_steps), .req1_ready(g_req1_ready),
    .cnt_en(g_cnt_en), .cnt_mode(g_cnt_mode), .count(g_count), .busy(g_busy), .done(g_done), .done_id(g_done_id)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from a single requester and follow it cycle by cycle.
  task automatic do_cmd(input bit id, input bit dir, input logic [2:0] steps);
    if (id) begin
      req1_valid = 1'b1; req1_dir = dir; req1_steps = steps;
    end else begin
      req0_valid = 1'b1; req0_dir = dir; req0_steps = steps;
    end
    #1;
    chk("ready_granted", id ? req1_ready : req0_ready, 8'd1);
    chk("ready_other",   id ? req0_ready : req1_ready, 8'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < int'(steps); k++) begin
      chk("step_en", cnt_en, 8'd1);
      chk("step_mode", cnt_mode, {7'd0, dir});
      chk("step_count", count, {5'd0, exp_cnt});
      exp_cnt = dir ? exp_cnt + 3'd1 : exp_cnt - 3'd1;
      tick();
    end
    chk("done", done, 8'd1);
    chk("done_id", done_id, {7'd0, id});
    chk("done_en", cnt_en, 8'd0);
    chk("done_busy", busy, 8'd1);
    chk("done_count", count, {5'd0, exp_cnt});
    tick();
    chk("idle_busy", busy, 8'd0);
    chk("idle_done", done, 8'd0);
    $display("cmd id=%0d dir=%0d steps=%0d -> count=%0d", id, dir, steps, count);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_count", count, 8'd0);
    chk("rst_en", cnt_en, 8'd0);
    chk("rst_mode", cnt_mode, 8'd0);
    chk("rst_busy", busy, 8'd0);
    chk("rst_done", done, 8'd0);
    chk("rst_done_id", done_id, 8'd0);
    rst = 1'b1;
    tick();

    // req0 up 3 from 0 -> 3
    exp_cnt = 3'd0;
    do_cmd(1'b0, 1'b1, 3'd3);
    chk("t1_count", count, 8'd3);

    // req1 down 2 -> 1, then down 3 -> 0,7,6
    do_cmd(1'b1, 1'b0, 3'd2);
    chk("t2a_count", count, 8'd1);
    do_cmd(1'b1, 1'b0, 3'd3);
    chk("t2b_count", count, 8'd6);

    // Both valid, steps=1: grants alternate starting with req0 (last grant was 1)
    req0_valid = 1'b1; req0_dir = 1'b1; req0_steps = 3'd1;
    req1_valid = 1'b1; req1_dir = 1'b1; req1_steps = 3'd1;
    exp_grant = 0; grants = 0; last_id = -1;
    #1;
    for (int i = 0; i < 12; i++) begin
      g0 = req0_ready; g1 = req1_ready;
      chk("rr_exclusive", {7'd0, g0 && g1}, 8'd0);
      if (g0 || g1) begin
        chk("rr_grant", {7'd0, g1}, exp_grant[7:0]);
        $display("rr cycle=%0d grant=%0d", i, g1);
        last_id = exp_grant;
        exp_grant = 1 - exp_grant;
        grants++;
      end
      if (done) chk("rr_done_id", {7'd0, done_id}, last_id[7:0]);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_grants", grants[7:0], 8'd4);
    chk("rr_count", count, 8'd2);

    // Gap instance: reset both, req0 up 2 -> pattern 1,0,0,1 then done
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    req0_valid = 1'b1; req0_dir = 1'b1; req0_steps = 3'd2;
    #1;
    chk("gap_ready", g_req0_ready, 8'd1);
    tick();
    req0_valid = 1'b0;
    chk("gap_en0", g_cnt_en, 8'd1);
    tick();
    chk("gap_en1", g_cnt_en, 8'd0);
    chk("gap_busy", g_busy, 8'd1);
    tick();
    chk("gap_en2", g_cnt_en, 8'd0);
    tick();
    chk("gap_en3", g_cnt_en, 8'd1);
    chk("gap_cnt3", g_count, 8'd1);
    tick();
    chk("gap_done", g_done, 8'd1);
    chk("gap_en4", g_cnt_en, 8'd0);
    chk("gap_count", g_count, 8'd2);
    tick();
    chk("gap_idle", g_busy, 8'd0);
    $display("gap cmd done count=%0d", g_count);

    // steps=0 on the no-gap instance (count is 2 after the shared command)
    chk("z_pre_count", count, 8'd2);
    req0_valid = 1'b1; req0_dir = 1'b0; req0_steps = 3'd0;
    #1;
    chk("z_ready", req0_ready, 8'd1);
    tick();
    req0_valid = 1'b0;
    chk("z_done", done, 8'd1);
    chk("z_en", cnt_en, 8'd0);
    chk("z_count", count, 8'd2);
    tick();
    chk("z_idle", busy, 8'd0);
    chk("z_count2", count, 8'd2);
    $display("zero-step cmd count=%0d", count);

    // Reset during the 2nd step of a 5-step command
    req0_valid = 1'b1; req0_dir = 1'b1; req0_steps = 3'd5;
    tick();
    req0_valid = 1'b0;
    chk("ab_step1", cnt_en, 8'd1);
    tick();
    chk("ab_step2", cnt_en, 8'd1);
    chk("ab_cnt2", count, 8'd3);
    rst = 1'b0;
    #1;
    chk("ab_en", cnt_en, 8'd0);
    chk("ab_count", count, 8'd0);
    chk("ab_busy", busy, 8'd0);
    chk("ab_mode", cnt_mode, 8'd0);
    chk("ab_done", done, 8'd0);
    tick();
    chk("ab_done2", done, 8'd0);
    rst = 1'b1;
    tick();
    chk("ab_done3", done, 8'd0);
    exp_cnt = 3'd0;
    do_cmd(1'b1, 1'b0, 3'd1);
    chk("ab_after", count, 8'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_step_arbiter.md
Name: counter_step_arbiter

Overview:
Controller that shares one 3-bit up/down step counter between two requesters. Each requester issues a command: a direction plus a step count. The block arbitrates round-robin and then sequences the counter one step per enable strobe. It drives the counter's mode and step-enable inputs, keeps a shadow of the counter value, and reports completion per requester.

Parameters:
INIT_COUNT, 0, shadow count value loaded at reset (3-bit, 0..7)
STEP_GAP, 0, idle cycles inserted between consecutive step strobes (0..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 command valid
req0_dir  input  1  requester 0 direction, 1=up, 0=down
req0_steps  input  3  requester 0 step count, 0..7
req0_ready  output  1  requester 0 command accepted this cycle
req1_valid  input  1  requester 1 command valid
req1_dir  input  1  requester 1 direction
req1_steps  input  3  requester 1 step count
req1_ready  output  1  requester 1 command accepted this cycle
cnt_en  output  1  step strobe to counter, one step per high cycle
cnt_mode  output  1  counter direction, 1=up, 0=down; valid while cnt_en=1
count  output  3  shadow of counter value after all issued strobes
busy  output  1  command in progress (any state but IDLE)
done  output  1  one-cycle completion pulse
done_id  output  1  requester whose command completed; valid while done=1

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, count=INIT_COUNT, cnt_en=0, cnt_mode=0, busy=0, done=0, done_id=0, last_grant=1 (so requester 0 wins first). Reset mid-command aborts it with no done pulse.
- States: IDLE, STEP, GAP, DONE. Outputs decode from registered state. Only reqN_ready is combinational.
- IDLE arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the one not equal to last_grant.
  - reqN_ready = (state==IDLE) && granted N. Never both high at once.
  - Transfer on valid&&ready at the clock edge: latch dir, steps and id; set last_grant=id.
  - steps==0: go to DONE. Otherwise load remaining=steps and go to STEP.
- STEP (one cycle): cnt_en=1, cnt_mode=latched dir. At the edge:
  - count increments (up) or decrements (down) modulo 8 (7->0 up, 0->7 down); remaining decrements.
  - If remaining reaches 0: go to DONE.
  - Else if STEP_GAP=0: stay in STEP.
  - Else load gap counter=STEP_GAP and go to GAP.
- GAP: cnt_en=0. Count down STEP_GAP cycles, then return to STEP.
- DONE (one cycle): done=1, done_id=latched id, cnt_en=0. Next state IDLE.
- busy=1 in STEP, GAP and DONE.
- Latency with STEP_GAP=0: acceptance at edge E. cnt_en is high for exactly N cycles immediately after E. done is high in cycle N+1 after E. ready can assert again in cycle N+2.
- Total cnt_en high cycles per command = steps exactly, with spacing STEP_GAP+1 cycles.
- cnt_mode holds the latched dir for the whole command. It returns to 0 only at reset.
- Requester inputs are ignored outside IDLE. A valid held during busy is served at the next IDLE per round-robin.
- A requester must hold valid and its payload until ready. The block does not depend on payload stability after acceptance.

Test Plan:
- Reset with INIT_COUNT=0; req0 up, steps=3 -> 3 consecutive cnt_en cycles, cnt_mode=1, count 1,2,3; done=1 with done_id=0 one cycle after the last strobe; busy then 0.
- count=1; req1 down, steps=3 -> count 0,7,6 (wrap-around); cnt_mode=0; done_id=1.
- Both valid every cycle after reset, steps=1 each -> grants alternate 0,1,0,1; req0_ready and req1_ready never high in the same cycle.
- STEP_GAP=2; req0 up, steps=2 -> cnt_en pattern 1,0,0,1 then done; count +2.
- req0 steps=0 -> accepted, no cnt_en, done pulse the cycle after acceptance, count unchanged.
- Assert rst low during the 2nd step of a 5-step command -> outputs immediately at reset values, no done pulse; after release, a new command is accepted normally from count=INIT_COUNT.
